// File: rtl/sad_min_collector.sv
// Tracks the minimum saturated SAD score (and its first position) over a frame of
// N_POS scores, then presents one match result over a valid/ready handshake.
module sad_min_collector #(
    parameter int unsigned          WIDTH     = 10,
    parameter logic [WIDTH-1:0]     THRESHOLD = 10'd500,
    parameter int unsigned          N_POS     = 64,
    parameter int unsigned          IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_score,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_score,
    output logic [IDX_W-1:0] res_index,
    output logic             res_found
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(N_POS - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             active_q;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [WIDTH-1:0] res_score_q, res_score_d;
    logic [IDX_W-1:0] res_index_q, res_index_d;
    logic             res_found_q, res_found_d;

    logic             accept;
    logic [WIDTH-1:0] score_sat;
    logic             new_min;
    logic [WIDTH-1:0] min_score;
    logic [IDX_W-1:0] min_idx;

    function automatic logic [WIDTH-1:0] sat_score(input logic [WIDTH-1:0] s);
        return (s > THRESHOLD) ? THRESHOLD : s;
    endfunction

    // active_q keeps in_ready low for the whole reset period and the edge after it
    assign in_ready  = (state_q == ACC) && active_q;
    assign res_valid = (state_q == HOLD);
    assign res_score = res_score_q;
    assign res_index = res_index_q;
    assign res_found = res_found_q;

    assign accept    = in_valid & in_ready;
    assign score_sat = sat_score(in_score);
    // Strict compare: a tie keeps the earlier position
    assign new_min   = score_sat < best_q;
    assign min_score = new_min ? score_sat : best_q;
    assign min_idx   = new_min ? pos_q : best_idx_q;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        res_score_d = res_score_q;
        res_index_d = res_index_q;
        res_found_d = res_found_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (pos_q == LAST_POS) begin
                        state_d     = HOLD;
                        pos_d       = '0;
                        best_d      = THRESHOLD;
                        best_idx_d  = '0;
                        res_score_d = min_score;
                        res_index_d = min_idx;
                        res_found_d = min_score < THRESHOLD;
                    end else begin
                        pos_d      = pos_q + 1'b1;
                        best_d     = min_score;
                        best_idx_d = min_idx;
                    end
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ACC;
            active_q    <= 1'b0;
            pos_q       <= '0;
            best_q      <= THRESHOLD;
            best_idx_q  <= '0;
            res_score_q <= '0;
            res_index_q <= '0;
            res_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= 1'b1;
            pos_q       <= pos_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            res_score_q <= res_score_d;
            res_index_q <= res_index_d;
            res_found_q <= res_found_d;
        end
    end

endmodule

// File: tb/tb_sad_min_collector.sv
// Directed bench for sad_min_collector with N_POS=4, IDX_W=2, THRESHOLD=500.
module tb_sad_min_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_score;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_score;
    logic [1:0] res_index;
    logic       res_found;

    int errors = 0;
    int checks = 0;

    sad_min_collector #(
        .WIDTH(10), .THRESHOLD(10'd500), .N_POS(4), .IDX_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_index(res_index), .res_found(res_found)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic send(input string tag, input logic [9:0] v);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_score = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_res(input string tag, input int sc, input int idx, input int fnd);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_score"}, 32'(res_score), 32'(sc));
        chk({tag, "_index"}, 32'(res_index), 32'(idx));
        chk({tag, "_found"}, 32'(res_found), 32'(fnd));
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_score  = '0;
        res_ready = 1'b0;

        // 1: reset held for three edges
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_res_score", 32'(res_score), 32'd0);
            chk("rst_res_index", 32'(res_index), 32'd0);
            chk("rst_res_found", 32'(res_found), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 2: basic frame
        send("t2a", 10'd300);
        send("t2b", 10'd120);
        send("t2c", 10'd450);
        chk("t2_early_valid", 32'(res_valid), 32'd0);
        send("t2d", 10'd200);
        chk_res("t2", 120, 1, 1);
        handshake("t2");

        // 3: all saturated, oversize scores clamped
        send("t3a", 10'd500);
        send("t3b", 10'd700);
        send("t3c", 10'd510);
        send("t3d", 10'd500);
        chk_res("t3", 500, 0, 0);
        handshake("t3");

        // 4: gaps and a tie on the minimum
        send("t4a", 10'd300);
        gap();
        send("t4b", 10'd80);
        gap();
        chk("t4_gap_valid", 32'(res_valid), 32'd0);
        send("t4c", 10'd90);
        gap();
        gap();
        send("t4d", 10'd80);
        chk_res("t4", 80, 1, 1);

        // 5: back-pressure with in_valid held high
        in_valid = 1'b1;
        in_score = 10'd10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_res("t5_hold", 80, 1, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t5_hs_valid", 32'(res_valid), 32'd0);
        chk("t5_hs_in_ready", 32'(in_ready), 32'd1);
        send("t5a", 10'd10);
        send("t5b", 10'd20);
        send("t5c", 10'd30);
        chk("t5_early_valid", 32'(res_valid), 32'd0);
        send("t5d", 10'd40);
        chk_res("t5", 10, 0, 1);
        handshake("t5");

        // 6: reset mid-frame discards the partial frame
        send("t6a", 10'd50);
        send("t6b", 10'd60);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_res_score", 32'(res_score), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_post_rst_in_ready", 32'(in_ready), 32'd1);
        send("t6c", 10'd400);
        send("t6d", 10'd300);
        chk("t6_mid_valid", 32'(res_valid), 32'd0);
        send("t6e", 10'd200);
        chk("t6_mid2_valid", 32'(res_valid), 32'd0);
        send("t6f", 10'd100);
        chk_res("t6", 100, 3, 1);
        handshake("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
